// File: rtl/mod461_chunk_reduce_ctrl.sv
// Reduces a wide operand modulo MOD by feeding one chunk per cycle to an external
// residue LUT bank and accumulating the returned residues with a single conditional subtract.
module mod461_chunk_reduce_ctrl #(
  parameter int N_BITS = 300,
  parameter int CHUNK  = 6,
  parameter int MOD    = 461,
  parameter int RW     = 9,
  parameter int NCH    = (N_BITS + CHUNK - 1) / CHUNK,
  parameter int IW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic [IW-1:0]     lut_sel,
  output logic [CHUNK-1:0]  lut_in,
  input  logic [RW-1:0]     lut_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_data,
  output logic              out_err
);

  localparam int          PW    = NCH * CHUNK;
  localparam logic [RW:0] MOD_W = (RW + 1)'(MOD);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   op;
  logic [RW-1:0]   acc, acc_nxt, res;
  logic [IW-1:0]   idx;
  logic            err;
  logic [RW:0]     sum;
  logic            last;

  assign last = (idx == IW'(NCH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    lut_sel   = '0;
    lut_in    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        lut_sel = idx;
        lut_in  = op[int'(idx) * CHUNK +: CHUNK];
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The sum keeps its carry bit so an out-of-range LUT value still compares correctly.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, lut_out};
    acc_nxt = (sum >= MOD_W) ? RW'(sum - MOD_W) : RW'(sum);
  end

  // NOTE: the operand register has no reset; it is always reloaded before it is read.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) op <= PW'(in_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
      err <= 1'b0;
      res <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= '0;
          idx <= '0;
          err <= 1'b0;
        end
        RUN: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if ({1'b0, lut_out} >= MOD_W) err <= 1'b1;
          if (last) res <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  // Result and flag stay in their registers after the handshake until the next operand.
  assign out_data = res;
  assign out_err  = err;

endmodule

// File: tb/tb_mod461_chunk_reduce_ctrl.sv
// Randomised self-checking bench: golden LUT bank, bit-serial big-integer mod reference,
// latency, back-pressure, mid-run reset and LUT error-flag scenarios.
module tb_mod461_chunk_reduce_ctrl;

  localparam int N_BITS = 300;
  localparam int NCH    = 50;
  localparam int MOD    = 461;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [299:0]  in_data;
  logic [5:0]    lut_sel;
  logic [5:0]    lut_in;
  logic [8:0]    lut_out;
  logic          out_valid;
  logic          out_ready;
  logic [8:0]    out_data;
  logic          out_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectations the monitor holds the DUT to whenever out_valid is high.
  int exp_data;
  bit exp_err;
  bit exp_skip_data;
  bit lut_bad;

  always #5 clk = ~clk;

  mod461_chunk_reduce_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_sel(lut_sel), .lut_in(lut_in), .lut_out(lut_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lut_model(input logic [5:0] c, input int k);
    int p = 1;
    for (int i = 0; i < 6 * k; i++) p = (p * 2) % MOD;
    return (int'(c) * p) % MOD;
  endfunction

  // Reference residue computed bit-serially, independent of the chunked scheme.
  function automatic int golden(input logic [299:0] d);
    int r = 0;
    for (int i = N_BITS - 1; i >= 0; i--) r = (r * 2 + int'(d[i])) % MOD;
    return r;
  endfunction

  function automatic logic [299:0] rand_op();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[299:0];
  endfunction

  always_comb begin
    lut_out = 9'(lut_model(lut_in, int'(lut_sel)));
    if (lut_bad && lut_sel == 6'd3) lut_out = 9'd500;
  end

  // Compare process: every cycle with a valid result is checked against the model.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_skip_data) check("out_data", out_data, exp_data);
      check("out_err", out_err, exp_err);
      check("in_ready_in_done", in_ready, 0);
    end
  end

  // Applies one operand, checks every RUN cycle, latency, optional stall, then handshakes.
  task automatic run_op(input logic [299:0] d, input int exp, input bit bad, input int stall);
    int cnt;
    int bound;
    logic [8:0] held;
    exp_data      = exp;
    exp_err       = bad;
    exp_skip_data = bad;
    lut_bad       = bad;
    out_ready     = (stall == 0);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    bound = 0;
    while (!in_ready && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      check("lut_sel", lut_sel, cnt);
      check("lut_in", lut_in, d[cnt*6 +: 6]);
      if (!bad) check("acc_below_mod", (dut.acc < 9'(MOD)), 1);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    check("latency_edges", cnt, NCH);
    check("lut_sel_idle_done", lut_sel, 0);
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 3 == 0);
      in_data  = rand_op();
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, held);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_data_hold", out_data, held);
    lut_bad = 1'b0;
  endtask

  initial begin
    logic [299:0] d;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    lut_bad = 1'b0; exp_data = 0; exp_err = 1'b0; exp_skip_data = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_lut_sel", lut_sel, 0);
    check("rst_lut_in", lut_in, 0);
    rst = 1'b0;

    // Pin the reference models with hand-computed values.
    check("model_lut_1_1", lut_model(6'd1, 1), 64);
    check("model_lut_63_2", lut_model(6'd63, 2), 349);
    check("model_gold_460", golden(300'd460), 460);
    check("model_gold_461", golden(300'd461), 0);
    check("model_gold_920", golden(300'd920), 459);
    check("model_gold_512", golden(300'd512), 51);

    run_op(300'd0,   0,   1'b0, 0);
    run_op(300'd460, 460, 1'b0, 0);
    run_op(300'd461, 0,   1'b0, 0);
    run_op(300'd920, 459, 1'b0, 0);
    run_op(300'd512, 51,  1'b0, 0);
    d = '1;
    run_op(d, golden(d), 1'b0, 0);

    // Back-pressure with ignored in_valid pulses, then the next operand.
    d = rand_op();
    run_op(d, golden(d), 1'b0, 20);
    d = rand_op();
    run_op(d, golden(d), 1'b0, 0);

    // Reset in the middle of RUN discards the operand.
    @(negedge clk);
    in_data = rand_op();
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_lut_sel", lut_sel, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 0);
    end
    run_op(300'd461, 0, 1'b0, 0);

    // Faulty LUT value flags the result; the following clean operand clears it.
    d = rand_op();
    run_op(d, 0, 1'b1, 0);
    d = rand_op();
    run_op(d, golden(d), 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      d = rand_op();
      run_op(d, golden(d), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
